// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges a single-cycle fast result stream and a long-latency slow
// stream onto the register file's single write port, queueing slow results that lose.
module wb_arbiter #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fast_valid_i,
  input  logic [ADDR_W-1:0]     fast_addr_i,
  input  logic [DATA_W-1:0]     fast_data_i,
  input  logic                  slow_valid_i,
  output logic                  slow_ready_o,
  input  logic [ADDR_W-1:0]     slow_addr_i,
  input  logic [DATA_W-1:0]     slow_data_i,
  output logic                  write_enable_o,
  output logic [ADDR_W-1:0]     write_addr_o,
  output logic [DATA_W-1:0]     write_data_o,
  output logic [2**ADDR_W-1:0]  busy_mask_o,
  output logic [CNT_W-1:0]      collisions_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W:0]    count;

  logic slow_acc, fast_hit, pop, bypass, push, collide;

  assign slow_ready_o = (count != (PTR_W+1)'(DEPTH));

  // Priority: fast > FIFO head > slow bypass; address 0 is never written or queued.
  always_comb begin
    slow_acc = slow_valid_i && slow_ready_o;
    fast_hit = fast_valid_i && (fast_addr_i != '0);
    pop      = !fast_valid_i && (count != '0);
    bypass   = !fast_valid_i && (count == '0) && slow_acc && (slow_addr_i != '0);
    push     = slow_acc && (slow_addr_i != '0) && !bypass;
    collide  = fast_valid_i && ((count != '0) || slow_acc);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      write_enable_o <= 1'b0;
      write_addr_o   <= '0;
      write_data_o   <= '0;
    end else begin
      write_enable_o <= fast_hit || pop || bypass;
      if (fast_hit) begin
        write_addr_o <= fast_addr_i;
        write_data_o <= fast_data_i;
      end else if (pop) begin
        write_addr_o <= q_addr[head];
        write_data_o <= q_data[head];
      end else if (bypass) begin
        write_addr_o <= slow_addr_i;
        write_data_o <= slow_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_addr[tail] <= slow_addr_i;
      q_data[tail] <= slow_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                         collisions_o <= '0;
    else if (collide && collisions_o != '1) collisions_o <= collisions_o + 1'b1;
  end

  // Walk the occupied window starting at head; pointers wrap naturally.
  always_comb begin
    busy_mask_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((PTR_W+1)'(i) < count)
        busy_mask_o[q_addr[head + PTR_W'(i)]] = 1'b1;
    end
  end

  a_fast_not_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    !(fast_valid_i && busy_mask_o[fast_addr_i]));

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic, all
// compared each cycle against a queue-based reference model.
module tb_wb_arbiter;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 4;
  localparam int          CMAX   = 15;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              fast_valid_i, slow_valid_i, slow_ready_o, write_enable_o;
  logic [ADDR_W-1:0] fast_addr_i, slow_addr_i, write_addr_o;
  logic [DATA_W-1:0] fast_data_i, slow_data_i, write_data_o;
  logic [31:0]       busy_mask_o;
  logic [CNT_W-1:0]  collisions_o;

  wb_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fast_valid_i(fast_valid_i), .fast_addr_i(fast_addr_i), .fast_data_i(fast_data_i),
    .slow_valid_i(slow_valid_i), .slow_ready_o(slow_ready_o),
    .slow_addr_i(slow_addr_i), .slow_data_i(slow_data_i),
    .write_enable_o(write_enable_o), .write_addr_o(write_addr_o),
    .write_data_o(write_data_o), .busy_mask_o(busy_mask_o), .collisions_o(collisions_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [4:0] a; logic [63:0] d; } ent_t;
  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [63:0] m_data;
  int          m_coll;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    foreach (q[i]) b[q[i].a] = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    q.delete();
    m_we = 1'b0; m_addr = '0; m_data = '0; m_coll = 0;
  endtask

  task automatic compare_all();
    check("we",    {63'd0, write_enable_o}, {63'd0, m_we});
    if (m_we) begin
      check("addr", {59'd0, write_addr_o}, {59'd0, m_addr});
      check("data", write_data_o, m_data);
    end
    check("ready", {63'd0, slow_ready_o}, {63'd0, q.size() != DEPTH});
    check("busy",  {32'd0, busy_mask_o}, {32'd0, model_busy()});
    check("coll",  {60'd0, collisions_o}, 64'(m_coll));
  endtask

  task automatic model_next(input logic fv, input logic [4:0] fa, input logic [63:0] fd,
                            input logic sv, input logic [4:0] sa, input logic [63:0] sd);
    int   n   = q.size();
    bit   acc = sv && (n != DEPTH);
    bit   byp = 1'b0;
    ent_t e;
    if (fv) begin
      m_we = (fa != 0);
      if (fa != 0) begin m_addr = fa; m_data = fd; end
    end else if (n > 0) begin
      e = q.pop_front();
      m_we = 1'b1; m_addr = e.a; m_data = e.d;
    end else if (acc && sa != 0) begin
      byp = 1'b1;
      m_we = 1'b1; m_addr = sa; m_data = sd;
    end else begin
      m_we = 1'b0;
    end
    if (acc && sa != 0 && !byp) begin
      e.a = sa; e.d = sd;
      q.push_back(e);
    end
    if (fv && (n > 0 || acc) && m_coll < CMAX) m_coll++;
  endtask

  // Check current outputs, drive one cycle of inputs, advance the model across the edge.
  task automatic cycle(input logic fv, input logic [4:0] fa, input logic [63:0] fd,
                       input logic sv, input logic [4:0] sa, input logic [63:0] sd);
    compare_all();
    fast_valid_i = fv; fast_addr_i = fa; fast_data_i = fd;
    slow_valid_i = sv; slow_addr_i = sa; slow_data_i = sd;
    model_next(fv, fa, fd, sv, sa, sd);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    fast_valid_i = 0; fast_addr_i = 0; fast_data_i = 0;
    slow_valid_i = 0; slow_addr_i = 0; slow_data_i = 0;
    rst_i = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_addr", {59'd0, write_addr_o}, 64'd0);
    check("rst_data", write_data_o, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    logic        fv, sv;
    logic [4:0]  fa, sa;
    logic [31:0] b;

    rst_i = 1'b1;
    fast_valid_i = 0; fast_addr_i = 0; fast_data_i = 0;
    slow_valid_i = 0; slow_addr_i = 0; slow_data_i = 0;
    @(negedge clk_i);
    do_reset();

    // fast only, then bypass into an empty FIFO
    cycle(1, 5, 64'hAA, 0, 0, 0);
    idle(2);
    cycle(0, 0, 0, 1, 7, 64'h11);
    idle(2);

    // collision: fast held three cycles, two slow results queue behind it
    cycle(1, 1, 64'h101, 1, 3, 64'h33);
    cycle(1, 1, 64'h102, 1, 4, 64'h44);
    check("busy_34", {32'd0, busy_mask_o}, 64'h18);
    cycle(1, 2, 64'h103, 0, 0, 0);
    idle(3);
    check("coll_3", {60'd0, collisions_o}, 64'd3);
    check("busy_clr", {32'd0, busy_mask_o}, 64'd0);

    // address 0 on both paths
    cycle(0, 0, 0, 1, 0, 64'hFF);
    cycle(1, 0, 64'hEE, 0, 0, 0);
    idle(2);

    // fill FIFO under fast pressure, hold a fifth slow, run counter into saturation
    for (int i = 0; i < 4; i++) cycle(1, 1, 64'(i), 1, 5'(10 + i), 64'(64'h1000 + i));
    check("full_ready", {63'd0, slow_ready_o}, 64'd0);
    for (int i = 0; i < 12; i++) cycle(1, 1, 64'(i), 1, 14, 64'h1014);
    check("coll_sat", {60'd0, collisions_o}, 64'(CMAX));
    cycle(0, 0, 0, 1, 14, 64'h1014);
    cycle(0, 0, 0, 1, 14, 64'h1014);
    idle(6);

    // reset while two entries are queued
    do_reset();
    cycle(1, 1, 64'h5, 1, 20, 64'h20);
    cycle(1, 1, 64'h6, 1, 21, 64'h21);
    check("drain_busy", {32'd0, busy_mask_o}, 64'h0030_0000);
    do_reset();
    idle(4);

    // random traffic; fast never targets a register the model reports busy
    for (int i = 0; i < 3000; i++) begin
      b  = model_busy();
      fv = ($urandom_range(0, 2) == 0);
      fa = 5'($urandom_range(0, 31));
      if (b[fa]) fa = 0;
      sv = ($urandom_range(0, 1) == 0);
      sa = 5'($urandom_range(0, 31));
      cycle(fv, fa, {$urandom, $urandom}, sv, sa, {$urandom, $urandom});
      if (i == 1500) do_reset();
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
